tvbg_run_controller: RTL

TVBG_RUN_CONTROLLER -- requirements
Module: tvbg_run_controller

---
 rtl/tvbg_run_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/tvbg_run_controller.sv
// Start/run sequencer for the IR code core: debounced start button, start handshake with timeout,
// bounded retry via core reset, and a latched fault state cleared by abort.
module tvbg_run_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned START_TIMEOUT   = 64,
  parameter int unsigned RETRY_MAX       = 3
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       button_in,
  input  logic       loop_enable_in,
  input  logic       abort_in,
  input  logic       core_busy_in,
  input  logic       core_fail_in,
  output logic       core_start_out,
  output logic       core_loop_out,
  output logic       core_reset_out,
  output logic       busy_out,
  output logic       fail_out,
  output logic       done_pulse_out,
  output logic [7:0] run_count_out
);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWaitBusy,
    StRun,
    StRecover,
    StFault
  } state_e;

  localparam logic [15:0] DebLast   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] ToLast    = 16'(START_TIMEOUT - 1);
  localparam logic [3:0]  RetryLim  = 4'(RETRY_MAX);

  logic [1:0]  sync_q;
  logic        deb_level_q;
  logic [15:0] deb_cnt_q;
  logic        start_req_q;

  state_e      state_q, state_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        rec_cnt_q, rec_cnt_d;
  logic        ret_idle_q, ret_idle_d;
  logic        loop_q, loop_d;
  logic        done_q, done_d;
  logic [7:0]  count_q, count_d;
  logic        rst_hold_q;
  logic        go_abort, go_fail;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      sync_q      <= 2'b00;
      deb_level_q <= 1'b0;
      deb_cnt_q   <= 16'd0;
      start_req_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], button_in};
      start_req_q <= 1'b0;
      if (sync_q[1] != deb_level_q) begin
        if (deb_cnt_q == DebLast) begin
          deb_level_q <= sync_q[1];
          deb_cnt_q   <= 16'd0;
          start_req_q <= sync_q[1];
        end else begin
          deb_cnt_q <= deb_cnt_q + 16'd1;
        end
      end else begin
        deb_cnt_q <= 16'd0;
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= StIdle;
      retry_q    <= 4'd0;
      to_cnt_q   <= 16'd0;
      rec_cnt_q  <= 1'b0;
      ret_idle_q <= 1'b0;
      loop_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= 8'd0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      to_cnt_q   <= to_cnt_d;
      rec_cnt_q  <= rec_cnt_d;
      ret_idle_q <= ret_idle_d;
      loop_q     <= loop_d;
      done_q     <= done_d;
      count_q    <= count_d;
      rst_hold_q <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    to_cnt_d   = to_cnt_q;
    rec_cnt_d  = 1'b0;
    ret_idle_d = ret_idle_q;
    loop_d     = loop_q;
    done_d     = 1'b0;
    count_d    = count_q;
    go_abort   = 1'b0;
    go_fail    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_req_q) begin
          state_d = StArm;
          retry_d = 4'd0;
        end
      end
      StArm: begin
        loop_d   = loop_enable_in;
        to_cnt_d = 16'd0;
        if (abort_in) go_abort = 1'b1;
        else          state_d  = StWaitBusy;
      end
      StWaitBusy: begin
        if (abort_in)                go_abort = 1'b1;
        else if (core_busy_in)       state_d  = StRun;
        else if (to_cnt_q == ToLast) go_fail  = 1'b1;
        else                         to_cnt_d = to_cnt_q + 16'd1;
      end
      StRun: begin
        if (abort_in)          go_abort = 1'b1;
        else if (core_fail_in) go_fail  = 1'b1;
        else if (!core_busy_in) begin
          state_d = StIdle;
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
        end
      end
      StRecover: begin
        if (!rec_cnt_q) rec_cnt_d = 1'b1;
        else            state_d   = ret_idle_q ? StIdle : StArm;
      end
      StFault: begin
        if (abort_in) begin
          state_d = StIdle;
          retry_d = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_abort) begin
      state_d    = StRecover;
      ret_idle_d = 1'b1;
    end else if (go_fail) begin
      if (retry_q < RetryLim) begin
        state_d    = StRecover;
        retry_d    = retry_q + 4'd1;
        ret_idle_d = 1'b0;
      end else begin
        state_d = StFault;
      end
    end
  end

  assign core_start_out = (state_q == StArm);
  assign core_loop_out  = loop_q;
  // Held high through reset and released on the first edge afterwards.
  assign core_reset_out = rst_hold_q | (state_q == StRecover);
  assign busy_out       = (state_q == StArm) || (state_q == StWaitBusy) ||
                          (state_q == StRun) || (state_q == StRecover);
  assign fail_out       = (state_q == StFault);
  assign done_pulse_out = done_q;
  assign run_count_out  = count_q;

endmodule
